// File: rtl/sum_acc_pkg.sv
// sum_pkg: shared types and helpers for the sum_acc burst accumulator.
// Holds the FSM state encoding, the overflow-mode constants and a helper
// that builds saturation limits for any accumulator width.
package sum_pkg;

    // Accumulator FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Overflow handling mode, latched when a burst starts
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Widest accumulator the saturation helper can describe
    localparam int SAT_W = 64;

    // Saturation limit for a given width. Unsigned: all ones.
    // Signed: max positive (0111..1) or min negative (1000..0).
    // Callers size-cast the result down to their own width.
    function automatic logic [SAT_W-1:0] sat_value(
        input int   width,
        input logic is_neg,
        input logic is_signed
    );
        logic [SAT_W-1:0] v;
        v = '0;
        for (int i = 0; i < SAT_W; i++) begin
            if (i < width - 1) begin
                v[i] = is_signed ? ~is_neg : 1'b1;
            end else if (i == width - 1) begin
                v[i] = is_signed ? is_neg : 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/sum_acc_if.sv
// sum_acc_if: burst/handshake bundle between a sample source/result sink
// (master) and the sum_acc accumulator (slave). clk and rst stay outside.
interface sum_acc_if #(
    parameter int NB_DATA   = 8,
    parameter int NB_ACC    = 9,
    parameter int N_SAMPLES = 4
);
    localparam int NB_CNT = $clog2(N_SAMPLES + 1);

    logic                i_start;
    logic                i_sat;
    logic                i_valid;
    logic [NB_DATA-1:0]  i_data;
    logic                o_ready;
    logic                i_ack;
    logic                o_valid;
    logic [NB_ACC-1:0]   o_sum;
    logic                o_ovf;
    logic [NB_CNT-1:0]   o_count;

    // Source / sink side
    modport master (
        output i_start, i_sat, i_valid, i_data, i_ack,
        input  o_ready, o_valid, o_sum, o_ovf, o_count
    );

    // Accumulator side
    modport slave (
        input  i_start, i_sat, i_valid, i_data, i_ack,
        output o_ready, o_valid, o_sum, o_ovf, o_count
    );

endinterface

// File: rtl/sum_acc_step.sv
// sum_step: one combinational accumulate step, acc + data, with overflow
// detection and wrap/saturate handling selected by mode.
// Build option: SUM_ACC_SIGNED_EN selects two's-complement arithmetic
// (sign-extended samples, signed overflow, clamp to max/min); without it
// the step is purely unsigned with zero-extended samples.
module sum_step
    import sum_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_ACC  = 9
) (
    input  logic [NB_ACC-1:0]  acc,
    input  logic [NB_DATA-1:0] data,
    input  logic               mode,
    output logic [NB_ACC-1:0]  next_acc,
    output logic               ovf
);

`ifdef SUM_ACC_SIGNED_EN

    localparam logic [NB_ACC-1:0] SAT_POS = NB_ACC'(sat_value(NB_ACC, 1'b0, 1'b1));
    localparam logic [NB_ACC-1:0] SAT_NEG = NB_ACC'(sat_value(NB_ACC, 1'b1, 1'b1));

    logic [NB_ACC-1:0] data_ext;
    logic [NB_ACC-1:0] sum_raw;

    // Signed add: overflow when both operands share a sign the result lacks;
    // the clamp direction follows the operand sign.
    always_comb begin
        data_ext = NB_ACC'($signed(data));
        sum_raw  = acc + data_ext;
        ovf      = (acc[NB_ACC-1] == data_ext[NB_ACC-1]) &&
                   (sum_raw[NB_ACC-1] != acc[NB_ACC-1]);
        next_acc = sum_raw;
        if (ovf && (mode == MODE_SAT)) begin
            next_acc = acc[NB_ACC-1] ? SAT_NEG : SAT_POS;
        end
    end

`else

    localparam logic [NB_ACC-1:0] SAT_MAX = NB_ACC'(sat_value(NB_ACC, 1'b0, 1'b0));

    logic [NB_ACC:0] sum_wide;

    // Unsigned add one bit wider than the accumulator; the extra bit is the
    // carry, and saturation pins the result at all ones.
    always_comb begin
        sum_wide = {1'b0, acc} + (NB_ACC + 1)'(data);
        ovf      = sum_wide[NB_ACC];
        next_acc = sum_wide[NB_ACC-1:0];
        if (ovf && (mode == MODE_SAT)) begin
            next_acc = SAT_MAX;
        end
    end

`endif

endmodule

// File: rtl/sum_acc.sv
// sum_acc: accumulates a burst of N_SAMPLES words into an NB_ACC-bit
// register. A start pulse opens the burst, samples arrive over valid/ready,
// and the result is held with a sticky overflow flag until acknowledged.
// Build option: SUM_ACC_SIGNED_EN (handled inside sum_step) switches the
// datapath to two's-complement arithmetic.
module sum_acc
    import sum_pkg::*;
#(
    parameter int NB_DATA   = 8,
    parameter int NB_ACC    = 9,
    parameter int N_SAMPLES = 4
) (
    input  logic     clk,
    input  logic     rst,
    sum_acc_if.slave bus
);

    localparam int NB_CNT = $clog2(N_SAMPLES + 1);
    localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(N_SAMPLES - 1);
    localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);

    state_t             state_q, state_d;
    logic [NB_ACC-1:0]  acc_q,   acc_d;
    logic [NB_CNT-1:0]  cnt_q,   cnt_d;
    logic               ovf_q,   ovf_d;
    logic               mode_q,  mode_d;

    logic [NB_ACC-1:0]  step_acc;
    logic               step_ovf;
    logic               xfer;

    // Single accumulate step on the current accumulator and incoming sample
    sum_step #(
        .NB_DATA (NB_DATA),
        .NB_ACC  (NB_ACC)
    ) u_step (
        .acc      (acc_q),
        .data     (bus.i_data),
        .mode     (mode_q),
        .next_acc (step_acc),
        .ovf      (step_ovf)
    );

    // A sample moves only while accumulating and the source offers one
    assign xfer = (state_q == ST_ACC) && bus.i_valid;

    // Next-state and datapath update; every register holds unless touched
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        mode_d  = mode_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d = ST_ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    mode_d  = bus.i_sat;
                end
            end
            ST_ACC: begin
                if (xfer) begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + CNT_ONE;
                    if (step_ovf) begin
                        ovf_d = 1'b1;
                    end
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.i_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            mode_q  <= MODE_WRAP;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            mode_q  <= mode_d;
        end
    end

    // Handshake flags decode straight from the state register
    always_comb begin
        bus.o_ready = (state_q == ST_ACC);
        bus.o_valid = (state_q == ST_DONE);
        bus.o_sum   = acc_q;
        bus.o_ovf   = ovf_q;
        bus.o_count = cnt_q;
    end

endmodule

// File: tb/tb_sum_acc.sv
// tb_sum_acc: directed bench for sum_acc with N_SAMPLES=4, 8-bit samples
// and a 9-bit accumulator. Expected partial sums are hand-computed.
module tb_sum_acc;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    sum_acc_if #(.NB_DATA(8), .NB_ACC(9), .N_SAMPLES(4)) bus ();

    sum_acc #(.NB_DATA(8), .NB_ACC(9), .N_SAMPLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_sum"},   32'(bus.o_sum),   32'd0);
        chk({tag, "_count"}, 32'(bus.o_count), 32'd0);
        chk({tag, "_ovf"},   32'(bus.o_ovf),   32'd0);
        chk({tag, "_ready"}, 32'(bus.o_ready), 32'd0);
        chk({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
    endtask

    // Runs one 4-sample burst, checking each partial sum; during stall
    // cycles i_start and i_ack are also asserted and must be ignored.
    task automatic burst(input string name, input logic sat,
                         input logic [3:0][7:0] d, input logic [3:0][8:0] p,
                         input logic [3:0] ov, input int stall);
        bus.i_start = 1'b1;
        bus.i_sat   = sat;
        step();
        bus.i_start = 1'b0;
        chk({name, "_start_ready"}, 32'(bus.o_ready), 32'd1);
        chk({name, "_start_sum"},   32'(bus.o_sum),   32'd0);
        chk({name, "_start_count"}, 32'(bus.o_count), 32'd0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                for (int s = 0; s < stall; s++) begin
                    bus.i_valid = 1'b0;
                    bus.i_start = 1'b1;
                    bus.i_ack   = 1'b1;
                    bus.i_data  = 8'hFF;
                    step();
                    chk({name, "_stall_count"}, 32'(bus.o_count), 32'(k));
                    chk({name, "_stall_sum"},   32'(bus.o_sum),   32'(p[k-1]));
                    chk({name, "_stall_ready"}, 32'(bus.o_ready), 32'd1);
                end
                bus.i_start = 1'b0;
                bus.i_ack   = 1'b0;
            end
            bus.i_valid = 1'b1;
            bus.i_data  = d[k];
            step();
            bus.i_valid = 1'b0;
            chk({name, "_sum"},   32'(bus.o_sum),   32'(p[k]));
            chk({name, "_count"}, 32'(bus.o_count), 32'(k + 1));
            chk({name, "_ovf"},   32'(bus.o_ovf),   32'(ov[k]));
            chk({name, "_valid"}, 32'(bus.o_valid), (k == 3) ? 32'd1 : 32'd0);
            $display("%s: sample %0d data=%0d sum=%0d ovf=%0d", name, k, d[k], bus.o_sum, bus.o_ovf);
        end
    endtask

    // Acknowledge with i_start also high; the FSM must land in IDLE, not ACC
    task automatic ack(input string name, input logic [8:0] sum_exp);
        bus.i_ack   = 1'b1;
        bus.i_start = 1'b1;
        step();
        bus.i_ack   = 1'b0;
        bus.i_start = 1'b0;
        chk({name, "_ack_valid"}, 32'(bus.o_valid), 32'd0);
        chk({name, "_ack_ready"}, 32'(bus.o_ready), 32'd0);
        chk({name, "_ack_sum"},   32'(bus.o_sum),   32'(sum_exp));
        $display("%s: acknowledged, held sum=%0d", name, bus.o_sum);
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_sat   = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_ack   = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_idle_reset("reset");
        $display("reset: sum=%0d count=%0d", bus.o_sum, bus.o_count);

        // i_valid in IDLE must not touch the accumulator
        bus.i_valid = 1'b1;
        bus.i_data  = 8'd5;
        step();
        step();
        bus.i_valid = 1'b0;
        chk_idle_reset("idle_valid");

        // Basic wrap-mode burst 10,20,30,40
        burst("basic", 1'b0, {8'd40, 8'd30, 8'd20, 8'd10},
              {9'd100, 9'd60, 9'd30, 9'd10}, 4'b0000, 0);
        ack("basic", 9'd100);

`ifdef SUM_ACC_SIGNED_EN
        // -100 x4, saturating: clamps at -256 (0x100)
        burst("s_sat", 1'b1, {8'h9C, 8'h9C, 8'h9C, 8'h9C},
              {9'h100, 9'h100, 9'h138, 9'h19C}, 4'b1100, 0);
        ack("s_sat", 9'h100);
        // -100 x4, wrap: -300 wraps to 212, then 112
        burst("s_wrap", 1'b0, {8'h9C, 8'h9C, 8'h9C, 8'h9C},
              {9'd112, 9'd212, 9'h138, 9'h19C}, 4'b1100, 0);
        ack("s_wrap", 9'd112);
`else
        // Wrap: 200,400,600->88,98
        burst("wrap", 1'b0, {8'd10, 8'd200, 8'd200, 8'd200},
              {9'd98, 9'd88, 9'd400, 9'd200}, 4'b1100, 0);
        ack("wrap", 9'd98);
        // Saturate: 200,400,511,511 (saturated + nonzero stays at max)
        burst("sat", 1'b1, {8'd10, 8'd200, 8'd200, 8'd200},
              {9'd511, 9'd511, 9'd400, 9'd200}, 4'b1100, 0);
        ack("sat", 9'd511);
        // Exactly reaching 511 and adding 0 must not overflow
        burst("edge", 1'b1, {8'd1, 8'd0, 8'd255, 8'd255},
              {9'd511, 9'd510, 9'd510, 9'd255}, 4'b0000, 0);
        ack("edge", 9'd511);
`endif

        // Stalls with stray i_start/i_ack during ACC
        burst("stall", 1'b0, {8'd40, 8'd30, 8'd20, 8'd10},
              {9'd100, 9'd60, 9'd30, 9'd10}, 4'b0000, 3);
        for (int h = 0; h < 5; h++) begin
            step();
            chk("hold_valid", 32'(bus.o_valid), 32'd1);
            chk("hold_sum",   32'(bus.o_sum),   32'd100);
            chk("hold_count", 32'(bus.o_count), 32'd4);
        end
        $display("hold: DONE held 5 cycles, sum=%0d", bus.o_sum);

        // Reset while in DONE
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle_reset("rst_done");
        $display("rst_done: sum=%0d valid=%0d", bus.o_sum, bus.o_valid);

        // Reset mid-burst after two samples
        bus.i_start = 1'b1;
        bus.i_sat   = 1'b1;
        step();
        bus.i_start = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = 8'd7;
        step();
        step();
        bus.i_valid = 1'b0;
        chk("mid_sum", 32'(bus.o_sum), 32'd14);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle_reset("rst_mid");
        $display("rst_mid: sum=%0d count=%0d", bus.o_sum, bus.o_count);

        burst("fresh", 1'b0, {8'd1, 8'd1, 8'd1, 8'd1},
              {9'd4, 9'd3, 9'd2, 9'd1}, 4'b0000, 0);
        ack("fresh", 9'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
